// File: rtl/axil_cmd_master.sv
// AXI4-Lite initiator: turns a single-outstanding command/response port into
// AXI4-Lite write or read transactions, with a watchdog that aborts hung ones.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | waiting for a command; cmd_ready high
// ST_WADDR_DATA | AW and W valids driven, each drops after its own handshake
// ST_WRESP      | bready high, waiting for the B beat
// ST_RADDR      | arvalid high, waiting for the AR handshake
// ST_RDATA      | rready high, waiting for the R beat
// ST_RSP        | rsp_valid high, holding the response until rsp_ready
module axil_cmd_master #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [2:0]        m_axi_awprot,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [2:0]        m_axi_arprot,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WADDR_DATA = 3'd1;
    localparam logic [2:0] ST_WRESP      = 3'd2;
    localparam logic [2:0] ST_RADDR      = 3'd3;
    localparam logic [2:0] ST_RDATA      = 3'd4;
    localparam logic [2:0] ST_RSP        = 3'd5;

    // Watchdog is a down-counter loaded on acceptance; expiry is the cycle it reads 1.
    localparam bit              WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam int              WD_W    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic accept;
    logic busy;
    logic bus_rsp_hs;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_RSP);
    // A B/R beat landing on the expiry cycle wins over the abort.
    assign bus_rsp_hs = ((state_q == ST_WRESP) && m_axi_bvalid && bready_q) ||
                        ((state_q == ST_RDATA) && m_axi_rvalid && rready_q);

    // Next-state, channel handshakes, response capture and watchdog abort.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_d          = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    wd_d    = WD_LOAD;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RADDR;
                    end
                end
            end
            ST_WADDR_DATA: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                // A dropped valid means that channel has already completed.
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (bus_rsp_hs) begin
                    rsp_resp_d    = m_axi_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    bready_d      = 1'b0;
                    state_d       = ST_RSP;
                end
            end
            ST_RADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (bus_rsp_hs) begin
                    rsp_resp_d    = m_axi_rresp;
                    rsp_rdata_d   = m_axi_rdata;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rready_d      = 1'b0;
                    state_d       = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (WD_EN && busy) begin
            if ((wd_q == WD_ONE) && !bus_rsp_hs) begin
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                bready_d      = 1'b0;
                arvalid_d     = 1'b0;
                rready_d      = 1'b0;
                rsp_resp_d    = 2'b10;
                rsp_rdata_d   = '0;
                rsp_timeout_d = 1'b1;
                rsp_valid_d   = 1'b1;
                wd_d          = '0;
                state_d       = ST_RSP;
            end else begin
                wd_d = wd_q - WD_ONE;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            wd_q          <= wd_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master, built with a 16-cycle watchdog.
module tb_axil_cmd_master;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid, awready;
    logic [2:0]        awprot;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wvalid, wready;
    logic [1:0]        bresp;
    logic              bvalid, bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid, arready;
    logic [2:0]        arprot;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid, rready;

    int checks = 0;
    int errors = 0;
    int aw_hs  = 0;
    int w_hs   = 0;
    int ar_hs  = 0;

    axil_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_awprot(awprot),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_arprot(arprot),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    always #5 clk = ~clk;

    // Handshake counters seen by the slave side.
    always @(posedge clk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready)   w_hs  <= w_hs + 1;
        if (arvalid && arready) ar_hs <= ar_hs + 1;
    end

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    endtask

    task automatic set_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        slave_idle();
        tick(); tick();
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            errors++; $display("FAIL reset_axi_ctrl: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rsp: got v=%b t=%b r=%b d=%h want all 0", rsp_valid, rsp_timeout, rsp_resp, rsp_rdata);
        end
        checks++;
        if ({awprot, arprot} !== 6'b0) begin errors++; $display("FAIL reset_prot: got %b want 0", {awprot, arprot}); end
        cmd_valid = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_aw_wait();
        int aw0, w0;
        aw0 = aw_hs; w0 = w_hs;
        slave_idle();
        wready = 1'b1;
        set_cmd(1'b1, 4'h0, 32'h41, 4'hF);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({awvalid, wvalid} !== 2'b11 || awaddr !== 4'h0 || wdata !== 32'h41 || wstrb !== 4'hF) begin
            errors++; $display("FAIL wr_issue: got v=%b a=%h d=%h s=%h want v=11 a=0 d=41 s=f", {awvalid, wvalid}, awaddr, wdata, wstrb);
        end
        tick();
        checks++;
        if ({awvalid, wvalid} !== 2'b10) begin errors++; $display("FAIL wr_w_first: got aw,w=%b want 10", {awvalid, wvalid}); end
        tick();
        checks++;
        if (awvalid !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL wr_aw_held: got aw=%b b=%b want 1 0", awvalid, bready); end
        awready = 1'b1;
        tick();
        awready = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b001) begin errors++; $display("FAIL wr_to_wresp: got aw,w,bready=%b want 001", {awvalid, wvalid, bready}); end
        checks++;
        if (aw_hs - aw0 !== 1 || w_hs - w0 !== 1) begin
            errors++; $display("FAIL wr_hs_count: got aw=%0d w=%0d want 1 1", aw_hs - aw0, w_hs - w0);
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0 || bready !== 1'b0) begin
            errors++; $display("FAIL wr_rsp: got v=%b r=%b t=%b bready=%b want 1 00 0 0", rsp_valid, rsp_resp, rsp_timeout, bready);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_rsp_done: got v=%b rdy=%b want 0 1", rsp_valid, cmd_ready); end
        slave_idle();
    endtask

    task automatic test_read_zero_wait();
        int ar0;
        ar0 = ar_hs;
        slave_idle();
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h2; rresp = 2'b00;
        set_cmd(1'b0, 4'h8, 32'h0, 4'h0);
        // Acceptance cycle is k; response expected in cycle k+3.
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 4'h8) begin errors++; $display("FAIL rd_ar: got v=%b a=%h want 1 8", arvalid, araddr); end
        tick();
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_k2: got ar=%b rr=%b rv=%b want 0 1 0", arvalid, rready, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h2 || rsp_resp !== 2'b00 || rsp_timeout !== 1'b0) begin
            errors++; $display("FAIL rd_rsp: got v=%b d=%h r=%b t=%b want 1 2 00 0", rsp_valid, rsp_rdata, rsp_resp, rsp_timeout);
        end
        checks++;
        if (ar_hs - ar0 !== 1 || rready !== 1'b0) begin errors++; $display("FAIL rd_ar_once: got hs=%0d rr=%b want 1 0", ar_hs - ar0, rready); end
        slave_idle();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_write_slverr();
        slave_idle();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        set_cmd(1'b1, 4'hC, 32'h1B, 4'hF);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (awaddr !== 4'hC || wdata !== 32'h1B) begin errors++; $display("FAIL slverr_issue: got a=%h d=%h want c 1b", awaddr, wdata); end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL slverr_rsp: got v=%b r=%b t=%b d=%h want 1 10 0 0", rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
        end
        slave_idle();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        slave_idle();
        set_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= TMO; i++) begin
            checks++;
            if (arvalid !== 1'b1 || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL tmo_wait_%0d: got ar=%b rv=%b want 1 0", i, arvalid, rsp_valid);
            end
            if (i < TMO) tick();
        end
        tick();
        checks++;
        if (arvalid !== 1'b0 || rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL tmo_abort: got ar=%b v=%b r=%b t=%b d=%h want 0 1 10 1 0", arvalid, rsp_valid, rsp_resp, rsp_timeout, rsp_rdata);
        end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        checks++;
        if (rready !== 1'b0 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_late_r: got rr=%b d=%h t=%b want 0 0 1", rready, rsp_rdata, rsp_timeout);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h55;
        set_cmd(1'b0, 4'h4, 32'h0, 4'h0);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL tmo_next_ready: got %b want 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h55 || rsp_timeout !== 1'b0 || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL tmo_next_rsp: got v=%b d=%h t=%b r=%b want 1 55 0 00", rsp_valid, rsp_rdata, rsp_timeout, rsp_resp);
        end
        slave_idle();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        slave_idle();
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h77; rresp = 2'b00;
        set_cmd(1'b1, 4'h0, 32'h99, 4'h3);
        tick();
        // Second command presented immediately and held; k+1 now.
        set_cmd(1'b0, 4'h8, 32'h0, 4'h0);
        for (int i = 1; i <= 2; i++) begin
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_%0d: got rdy=%b want 0", i, cmd_ready); end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin
                errors++; $display("FAIL b2b_hold_%0d: got rdy=%b v=%b r=%b d=%h t=%b want 0 1 00 0 0", i, cmd_ready, rsp_valid, rsp_resp, rsp_rdata, rsp_timeout);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept: got rdy=%b v=%b want 1 0", cmd_ready, rsp_valid); end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (arvalid !== 1'b1 || araddr !== 4'h8) begin errors++; $display("FAIL b2b_ar: got v=%b a=%h want 1 8", arvalid, araddr); end
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77) begin errors++; $display("FAIL b2b_rsp2: got v=%b d=%h want 1 77", rsp_valid, rsp_rdata); end
        slave_idle();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        slave_idle();
        awready = 1'b1; wready = 1'b1;
        set_cmd(1'b1, 4'h4, 32'h12, 4'hF);
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (bready !== 1'b1) begin errors++; $display("FAIL rst_in_wresp: got bready=%b want 1", bready); end
        rst = 1'b1;
        tick();
        checks++;
        if (bready !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got bready=%b v=%b rdy=%b want 0 0 0", bready, rsp_valid, cmd_ready);
        end
        rst = 1'b0;
        bvalid = 1'b1;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_idle: got rdy=%b want 1", cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid !== 1'b0 || bready !== 1'b0) begin
                errors++; $display("FAIL rst_no_rsp_%0d: got v=%b bready=%b want 0 0", i, rsp_valid, bready);
            end
            tick();
        end
        slave_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_aw_wait();
        test_read_zero_wait();
        test_write_slverr();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
AXI4-Lite initiator that converts a simple single-outstanding command/response interface into AXI4-Lite write and read transactions. It drives the UART AXI4-Lite peripheral, and any other AXI4-Lite slave on the SoC interconnect, from a sequencer, test controller or boot engine. It tracks the AW and W channels independently and captures B/R responses. A programmable watchdog recovers from hung slaves.

Parameters:
ADDR_W, 4, AXI address width (the UART map uses 0x0/0x4/0x8/0xC).
DATA_W, 32, AXI data width. Fixed at 32; other values are unsupported.
TIMEOUT_CYCLES, 256, cycles from command acceptance to abort. A value of 0 disables the watchdog.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target byte address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  4  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
rsp_timeout  out  1  transaction aborted by watchdog
m_axi_awaddr, m_axi_awvalid (out), m_axi_awready (in)
m_axi_awprot (out, 3)
m_axi_wdata, m_axi_wstrb, m_axi_wvalid (out), m_axi_wready (in)
m_axi_bresp (in, 2), m_axi_bvalid (in), m_axi_bready (out)
m_axi_araddr, m_axi_arvalid (out), m_axi_arready (in)
m_axi_arprot (out, 3)
m_axi_rdata (in), m_axi_rresp (in, 2), m_axi_rvalid (in), m_axi_rready (out)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; all m_axi_*valid, bready, rready = 0; rsp_valid=0; rsp_rdata=0; rsp_resp=0; rsp_timeout=0; watchdog=0. cmd_ready=0 while rst is high.
- m_axi_awprot and m_axi_arprot are tied to 3'b000. All AXI outputs are registered.
- cmd_ready = (state==IDLE) && !rst. On acceptance, addr, wdata and wstrb are latched. AXI outputs come only from the latched copies.
- States: IDLE, WADDR_DATA, WRESP, RADDR, RDATA, RSP.
- IDLE -> WADDR_DATA on an accepted write. awvalid and wvalid rise together on the next cycle.
- WADDR_DATA: each valid drops on the cycle after its own handshake. AW and W may complete in either order or in the same cycle. Move to WRESP once both have completed, with bready=1 in WRESP.
- WRESP: on the bvalid && bready handshake, capture bresp, set rsp_rdata=0, drop bready, go to RSP.
- IDLE -> RADDR on an accepted read, with arvalid=1 on the next cycle. On the AR handshake, drop arvalid and go to RDATA with rready=1.
- RDATA: on the R handshake, capture rdata and rresp, drop rready, go to RSP.
- RSP: rsp_valid=1. rsp_rdata, rsp_resp and rsp_timeout stay stable until rsp_ready. Then rsp_valid drops and state returns to IDLE. A new command can be accepted on the following cycle.
- Minimum latency with zero-wait slaves: the write response appears 3 cycles after acceptance and the read response 3 cycles after acceptance. This gives back-to-back throughput of one transaction per 4 cycles.
- Watchdog: counts from the cycle after acceptance while state is not IDLE or RSP. When the count reaches TIMEOUT_CYCLES:
  - all valid and ready outputs are forced to 0;
  - rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0;
  - state goes to RSP.
  This deliberate protocol abort exists for hung-bus recovery only. A late B or R beat after an abort is ignored, because bready and rready are 0.
- The watchdog does not run in RSP, so response backpressure never times out.
- A response handshake in the same cycle as the watchdog expiry completes normally; the handshake takes priority.
- rst asserted mid-transaction: all outputs return to reset values on the next edge, and no response is produced for the in-flight command.
- cmd_* inputs are ignored whenever cmd_ready=0.

Test Plan:
- Write addr=0x0, wdata=0x41, wstrb=0xF. Slave holds awready low 3 cycles; wready immediate -> exactly one AW and one W handshake. wvalid drops before awvalid. Then bready=1, bresp=00 -> rsp_valid with rsp_resp=00, rsp_timeout=0.
- Read addr=0x8, slave returns rdata=0x00000002, rresp=00 with zero wait -> rsp_rdata=0x2 exactly 3 cycles after acceptance. arvalid high for exactly 1 cycle.
- Write addr=0xC, wdata=0x1B, slave returns bresp=2'b10 -> rsp_resp=2'b10, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT_CYCLES=16, read addr=0x4, arready stuck at 0 -> arvalid is forced low and rsp_valid rises after 16 cycles with rsp_resp=2'b10, rsp_timeout=1. The next command is accepted normally.
- rsp_ready held low for 5 cycles with cmd_valid high -> cmd_ready stays 0 and the rsp_* values stay stable. The second command is accepted on the cycle after the rsp handshake.
- rst pulsed for 1 cycle while in WRESP -> bready=0 and rsp_valid=0 on the next edge, and state returns to IDLE. No response is produced for the in-flight command.
